// File: rtl/usbfs_host_serial_sched.sv
// Host-side transaction scheduler: periodic SOF, bulk OUT from a packed byte stream, bulk IN polls unpacked to a byte stream.
// Define USBFS_HOST_SCHED_STATS_EN to add saturating NAK/TIMEOUT counters on o_nakCount/o_timeoutCount.
module usbfs_host_serial_sched #(
  parameter int unsigned MAX_PKT      = 8,
  parameter int unsigned DEV_ADDR     = 1,
  parameter int unsigned ENDP         = 1,
  parameter int unsigned FRAME_CYCLES = 48000,
  parameter int unsigned SOF_GUARD    = 1000,
  parameter int unsigned MAX_RETRY    = 3,
  localparam int unsigned DATA_W      = 8 * MAX_PKT,
  localparam int unsigned NBYTES_W    = $clog2(MAX_PKT) + 1
) (
  input  logic                i_clk_48MHz,
  input  logic                i_rst,
  input  logic                i_hostToDev_valid,
  output logic                o_hostToDev_ready,
  input  logic [7:0]          i_hostToDev_data,
  output logic                o_devToHost_valid,
  input  logic                i_devToHost_ready,
  output logic [7:0]          o_devToHost_data,
  output logic                o_txnReq,
  output logic [3:0]          o_txnType,
  output logic [6:0]          o_devAddr,
  output logic [3:0]          o_endp,
  output logic                o_txToggle,
  output logic [DATA_W-1:0]   o_txData,
  output logic [NBYTES_W-1:0] o_txData_nBytes,
  output logic [10:0]         o_frameNumber,
  input  logic                i_txnDone,
  input  logic [1:0]          i_txnResult,
  input  logic                i_rxToggle,
  input  logic [DATA_W-1:0]   i_rxData,
  input  logic [NBYTES_W-1:0] i_rxData_nBytes,
  output logic                o_halted
`ifdef USBFS_HOST_SCHED_STATS_EN
  ,
  output logic [15:0]         o_nakCount,
  output logic [15:0]         o_timeoutCount
`endif
);

  localparam int unsigned FC_W    = $clog2(FRAME_CYCLES);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [FC_W-1:0]     FC_LAST     = FC_W'(FRAME_CYCLES - 1);
  localparam logic [FC_W-1:0]     GUARD_START = FC_W'(FRAME_CYCLES - SOF_GUARD);
  localparam logic [NBYTES_W-1:0] PKT_FULL    = NBYTES_W'(MAX_PKT);
  localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [6:0]          ADDR        = 7'(DEV_ADDR);
  localparam logic [3:0]          EP          = 4'(ENDP);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SOF    = 3'd1;
  localparam logic [2:0] ST_OUT    = 3'd2;
  localparam logic [2:0] ST_IN     = 3'd3;
  localparam logic [2:0] ST_UNPACK = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [1:0] RES_ACK     = 2'd0;
  localparam logic [1:0] RES_NAK     = 2'd1;
  localparam logic [1:0] RES_STALL   = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  localparam logic [3:0] TYPE_SOF = 4'b1000;
  localparam logic [3:0] TYPE_OUT = 4'b0010;
  localparam logic [3:0] TYPE_IN  = 4'b0001;

  logic [2:0]          state;
  logic [FC_W-1:0]     frameCnt;
  logic [10:0]         frameNumber;
  logic                sofPending;
  logic                outToggle;
  logic                inToggle;
  logic [DATA_W-1:0]   packBuf;
  logic [NBYTES_W-1:0] packCnt;
  logic [DATA_W-1:0]   unpackBuf;
  logic [NBYTES_W-1:0] unpackLeft;
  logic [RETRY_W-1:0]  retryCnt;
  logic                txnReq;
  logic                halted;

  logic                inGuard;
  logic                byteAccept;
  logic                devPop;
  logic                txnFinish;
  logic [RETRY_W-1:0]  nextRetry;

  assign inGuard    = frameCnt >= GUARD_START;
  assign byteAccept = i_hostToDev_valid && o_hostToDev_ready;
  assign devPop     = o_devToHost_valid && i_devToHost_ready;
  assign txnFinish  = txnReq && i_txnDone;
  assign nextRetry  = retryCnt + 1'b1;

  assign o_hostToDev_ready = (state == ST_IDLE) && (packCnt < PKT_FULL) && !sofPending;
  assign o_devToHost_valid = (state == ST_UNPACK);
  assign o_devToHost_data  = o_devToHost_valid ? unpackBuf[7:0] : '0;
  assign o_txnReq          = txnReq;
  assign o_frameNumber     = frameNumber;
  assign o_halted          = halted;

  // Request fields are only driven while a request is outstanding; all sources are frozen until done.
  always_comb begin
    o_txnType       = '0;
    o_devAddr       = '0;
    o_endp          = '0;
    o_txToggle      = 1'b0;
    o_txData        = '0;
    o_txData_nBytes = '0;
    if (txnReq) begin
      case (state)
        ST_SOF: o_txnType = TYPE_SOF;
        ST_OUT: begin
          o_txnType       = TYPE_OUT;
          o_devAddr       = ADDR;
          o_endp          = EP;
          o_txToggle      = outToggle;
          o_txData        = packBuf;
          o_txData_nBytes = packCnt;
        end
        ST_IN: begin
          o_txnType = TYPE_IN;
          o_devAddr = ADDR;
          o_endp    = EP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_48MHz) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      frameCnt    <= '0;
      frameNumber <= '0;
      sofPending  <= 1'b1;
      outToggle   <= 1'b0;
      inToggle    <= 1'b0;
      packBuf     <= '0;
      packCnt     <= '0;
      unpackBuf   <= '0;
      unpackLeft  <= '0;
      retryCnt    <= '0;
      txnReq      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (byteAccept) begin
        for (int unsigned i = 0; i < MAX_PKT; i++) begin
          if (packCnt == NBYTES_W'(i)) packBuf[8*i +: 8] <= i_hostToDev_data;
        end
        packCnt <= packCnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // A byte accepted this cycle keeps us gathering so a back-to-back stream fills one packet.
          if (sofPending) begin
            state <= ST_SOF;
          end else if (!inGuard && ((packCnt == PKT_FULL) || (packCnt != '0 && !byteAccept))) begin
            state <= ST_OUT;
          end else if (!inGuard && !byteAccept && unpackLeft == '0) begin
            state <= ST_IN;
          end
        end

        ST_SOF: begin
          if (!txnReq) begin
            txnReq <= 1'b1;
          end else if (i_txnDone) begin
            txnReq      <= 1'b0;
            sofPending  <= 1'b0;
            frameNumber <= frameNumber + 1'b1;
            state       <= halted ? ST_HALT : ST_IDLE;
          end
        end

        ST_OUT: begin
          if (!txnReq) begin
            txnReq <= 1'b1;
          end else if (i_txnDone) begin
            txnReq <= 1'b0;
            state  <= ST_IDLE;
            case (i_txnResult)
              RES_ACK: begin
                outToggle <= ~outToggle;
                packBuf   <= '0;
                packCnt   <= '0;
                retryCnt  <= '0;
              end
              RES_NAK: retryCnt <= '0;
              RES_STALL: begin
                halted <= 1'b1;
                state  <= ST_HALT;
              end
              default: begin
                retryCnt <= nextRetry;
                if (nextRetry == RETRY_LIMIT) begin
                  halted <= 1'b1;
                  state  <= ST_HALT;
                end
              end
            endcase
          end
        end

        ST_IN: begin
          if (!txnReq) begin
            txnReq <= 1'b1;
          end else if (i_txnDone) begin
            txnReq <= 1'b0;
            state  <= ST_IDLE;
            case (i_txnResult)
              RES_ACK: begin
                retryCnt <= '0;
                // A repeated toggle means the device resent data we already took; drop it.
                if (i_rxToggle == inToggle) begin
                  inToggle <= ~inToggle;
                  if (i_rxData_nBytes != '0) begin
                    unpackBuf  <= i_rxData;
                    unpackLeft <= i_rxData_nBytes;
                    state      <= ST_UNPACK;
                  end
                end
              end
              RES_NAK: retryCnt <= '0;
              RES_STALL: begin
                halted <= 1'b1;
                state  <= ST_HALT;
              end
              default: begin
                retryCnt <= nextRetry;
                if (nextRetry == RETRY_LIMIT) begin
                  halted <= 1'b1;
                  state  <= ST_HALT;
                end
              end
            endcase
          end
        end

        ST_UNPACK: begin
          if (devPop) begin
            unpackBuf  <= {8'h00, unpackBuf[DATA_W-1:8]};
            unpackLeft <= unpackLeft - 1'b1;
            if (unpackLeft == NBYTES_W'(1)) state <= ST_IDLE;
          end
        end

        ST_HALT: begin
          if (sofPending) state <= ST_SOF;
        end

        default: state <= ST_IDLE;
      endcase

      // Placed after the FSM so a wrap in the same cycle as an SOF completion re-arms sofPending.
      if (frameCnt == FC_LAST) begin
        frameCnt   <= '0;
        sofPending <= 1'b1;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

`ifdef USBFS_HOST_SCHED_STATS_EN
  always_ff @(posedge i_clk_48MHz) begin
    if (i_rst) begin
      o_nakCount     <= '0;
      o_timeoutCount <= '0;
    end else if (txnFinish && (state == ST_OUT || state == ST_IN)) begin
      if (i_txnResult == RES_NAK && o_nakCount != '1) o_nakCount <= o_nakCount + 1'b1;
      if (i_txnResult == RES_TIMEOUT && o_timeoutCount != '1) o_timeoutCount <= o_timeoutCount + 1'b1;
    end
  end
`else
  logic unusedFinish;
  assign unusedFinish = txnFinish;
`endif

endmodule

// File: doc/usbfs_host_serial_sched.md
Name: usbfs_host_serial_sched

Overview:
Host-side counterpart of the device serial function. It schedules full-speed transactions for a host-mode transaction engine:
- SOF every 1 ms.
- OUT transactions that carry packed bytes from a byte stream.
- IN polls whose payload is unpacked into a byte stream.
- Tracks data toggles and handles ACK/NAK/STALL/timeout.

It sits between a host-mode usbfsTxn-style engine and user byte streams, targeting a device's bulk endpoint pair.

Parameters:
- MAX_PKT, 8, wMaxPacketSize in {8,16,32,64}; DATA_W=8*MAX_PKT, NBYTES_W=$clog2(MAX_PKT)+1
- DEV_ADDR, 1, 7b target device address
- ENDP, 1, 4b endpoint number used for both OUT and IN
- FRAME_CYCLES, 48000, clock cycles per frame
- SOF_GUARD, 1000, no new OUT/IN once frame counter >= FRAME_CYCLES-SOF_GUARD
- MAX_RETRY, 3, consecutive timeouts before halt

Ports:
- i_clk_48MHz  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_hostToDev_valid  in  1  byte to send to device
- o_hostToDev_ready  out  1  byte accepted when valid&ready
- i_hostToDev_data  in  8  byte
- o_devToHost_valid  out  1  byte received from device
- i_devToHost_ready  in  1  consumer ready
- o_devToHost_data  out  8  byte
- o_txnReq  out  1  request to engine; held until i_txnDone
- o_txnType  out  4  onehot {SOF,SETUP,OUT,IN}; SETUP never used
- o_devAddr  out  7  DEV_ADDR during OUT/IN
- o_endp  out  4  ENDP during OUT/IN
- o_txToggle  out  1  DATA0/DATA1 select for OUT
- o_txData  out  DATA_W  {byteN..byte0}, byte0 sent first
- o_txData_nBytes  out  NBYTES_W  OUT payload length
- o_frameNumber  out  11  frame number for SOF
- i_txnDone  in  1  single-cycle pulse: transaction finished
- i_txnResult  in  2  0=ACK,1=NAK,2=STALL,3=TIMEOUT; valid with i_txnDone
- i_rxToggle  in  1  PID toggle of received IN data; valid with i_txnDone
- i_rxData  in  DATA_W  IN payload, byte0 in LSBs
- i_rxData_nBytes  in  NBYTES_W  IN payload length (0..MAX_PKT)
- o_halted  out  1  sticky halt (STALL or retries exhausted)

Behaviour:
Reset values:
- All outputs 0; o_txnType=0.
- State IDLE, frame counter 0, frameNumber 0, both toggles 0, pack and unpack buffers empty, retry count 0, sofPending=1.

Frame counter:
- Counts 0..FRAME_CYCLES-1 and wraps.
- Wrap sets sofPending.
- Counts in every state, including HALT.

States and transitions:
- IDLE, priority order:
  - sofPending -> SOF.
  - else if not in guard band and pack count==MAX_PKT, or pack count>0 with no accepted byte this cycle -> OUT.
  - else if not in guard band and unpack buffer empty -> IN.
- SOF:
  - o_txnReq=1, txnType=SOF.
  - On i_txnDone: clear sofPending, frameNumber+=1 mod 2048, -> IDLE. Result is ignored.
- OUT:
  - o_txnReq=1, payload = pack buffer, o_txToggle = outToggle.
  - On done:
    - ACK: flip outToggle, empty pack buffer, retry=0.
    - NAK: retry=0; data and toggle kept.
    - TIMEOUT: retry+=1; data and toggle kept.
    - STALL: -> HALT.
  - Otherwise -> IDLE.
- IN:
  - o_txnReq=1.
  - On ACK:
    - If i_rxToggle==inToggle: flip inToggle, latch payload; if nBytes>0 -> UNPACK, else -> IDLE.
    - Toggle mismatch: duplicate; discard -> IDLE.
  - NAK -> IDLE.
  - TIMEOUT: retry+=1 -> IDLE.
  - STALL -> HALT.
- UNPACK:
  - Present bytes 0..n-1 in order; advance on valid&ready.
  - After the last byte -> IDLE.
  - SOF is deferred until the return to IDLE.
- HALT:
  - Terminal until i_rst; o_halted=1.
  - No requests issued except SOF, which continues every frame to keep the device unsuspended.

Retry limit:
- Retry count reaching MAX_RETRY -> HALT.

Byte input (pack buffer):
- o_hostToDev_ready=1 only in IDLE with pack count<MAX_PKT and sofPending=0.
- Accepted byte goes to slot count, count+1.

Request interface:
- o_txnReq rises in the cycle after entering a request state.
- All request outputs stay stable until i_txnDone.
- i_txnDone while o_txnReq=0 is ignored.

Boundaries:
- Frame wrap during OUT/IN: the transaction completes first, then SOF.
- Reset mid-transaction: o_txnReq drops next cycle; buffered bytes are lost.

Optional Feature:
USBFS_HOST_SCHED_STATS_EN:
- Defined: adds outputs o_nakCount[15:0] and o_timeoutCount[15:0].
  - Saturating counters of NAK and TIMEOUT results.
  - Cleared by reset.
- Undefined: the ports and counters are absent.

Test Plan:
- Reset, no traffic, FRAME_CYCLES=48000 -> SOF requests at cycles ~1, ~48001, ~96001; o_frameNumber 0,1,2; wrap from 2047 to 0 checked.
- Push 8 bytes 0x00..0x07 back-to-back, engine ACKs -> OUT with nBytes=8, txData=0x0706050403020100, toggle 0; next OUT uses toggle 1.
- Push 3 bytes then idle -> OUT nBytes=3. Engine NAKs twice then ACKs -> same payload and toggle on all 3 attempts.
- IN ACK, rxToggle=0, 4 bytes 0xA1..0xA4 -> devToHost emits A1,A2,A3,A4 honouring ready stalls. Repeat with rxToggle=0 -> discarded, no bytes output.
- Three consecutive TIMEOUTs -> o_halted=1, only SOF requests afterwards. STALL on IN -> halt immediately.
- Guard band: byte arrives at counter=47500 -> no OUT until after the next SOF.
